fru_filter_ctrl: RTL and testbench

FRU_FILTER_CTRL -- requirements
Module: fru_filter_ctrl

---
 rtl/fru_pkg.sv | 18 +
 rtl/fru_hold_counter.sv | 36 +++
 rtl/fru_filter_ctrl.sv | 143 ++++++++++++++
 tb/tb_fru_filter_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fru_pkg.sv
// Shared types and helpers for the filter-override controller.
package fru_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LOADED = 3'd2,
    ST_ARMED  = 3'd3,
    ST_ACTIVE = 3'd4
  } fru_state_e;

  // Beats needed to ship a {RegConst, BypassEn} image of 2*filter_size bits.
  function automatic int unsigned nbeats(input int unsigned filter_size,
                                         input int unsigned word_w);
    return (2 * filter_size + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/fru_hold_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module fru_hold_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fru_filter_ctrl.sv
// Loads a bypass/constant image over a beat stream and drives it to the
// signal filter unit for a trigger-started override window.
module fru_filter_ctrl
  import fru_pkg::*;
#(
  parameter int FILTER_SIZE = 10,
  parameter int WORD_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [WORD_W-1:0]      cfg_data,
  input  logic                   cfg_last,
  input  logic                   arm,
  input  logic                   disarm,
  input  logic                   trigger,
  input  logic [CNT_W-1:0]       hold_cycles,
  output logic [FILTER_SIZE-1:0] BypassEn,
  output logic [FILTER_SIZE-1:0] RegConst,
  output logic [2:0]             state_o,
  output logic                   cfg_err
);

  localparam int unsigned IMG_W  = 2 * FILTER_SIZE;
  localparam int unsigned NBEATS = nbeats(FILTER_SIZE, WORD_W);
  localparam int unsigned BCW    = $clog2(NBEATS + 1);
  localparam logic [BCW-1:0] NB_L = BCW'(NBEATS);

  fru_state_e             state_q, state_d;
  logic [BCW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [IMG_W-1:0]       staging_q, staging_d;
  logic [IMG_W-1:0]       shadow_q, shadow_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [FILTER_SIZE-1:0] bypass_q, bypass_d;
  logic [FILTER_SIZE-1:0] regconst_q, regconst_d;

  logic                   accept;
  logic [BCW-1:0]         beat_idx, beat_num;
  logic                   cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]       cnt;

  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_LOADED);
  assign accept    = cfg_valid && cfg_ready;
  assign beat_idx  = (state_q == ST_LOAD) ? beat_cnt_q : '0;
  assign beat_num  = beat_idx + 1'b1;

  fru_hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (hold_cycles),
    .dec      (cnt_dec),
    .cnt_o    (cnt),
    .zero_o   (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    staging_d  = staging_q;
    shadow_d   = shadow_q;
    cfg_err_d  = cfg_err_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    if (accept) begin
      if (state_q != ST_LOAD) begin
        staging_d = '0;
      end
      // Bits beyond the image width in the final beat are dropped here.
      for (int unsigned k = 0; k < IMG_W; k++) begin
        if (beat_idx == BCW'(k / WORD_W)) begin
          staging_d[k] = cfg_data[k % WORD_W];
        end
      end
      beat_cnt_d = beat_num;
      if ((beat_num == NB_L) && cfg_last) begin
        state_d    = ST_LOADED;
        shadow_d   = staging_d;
        cfg_err_d  = 1'b0;
        beat_cnt_d = '0;
      end else if ((beat_num == NB_L) || cfg_last) begin
        state_d    = ST_IDLE;
        staging_d  = '0;
        cfg_err_d  = 1'b1;
        beat_cnt_d = '0;
      end else begin
        state_d = ST_LOAD;
      end
    end else begin
      unique case (state_q)
        ST_LOADED: if (arm) state_d = ST_ARMED;
        ST_ARMED: begin
          if (disarm) begin
            state_d = ST_LOADED;
          end else if (trigger) begin
            state_d  = ST_ACTIVE;
            cnt_load = 1'b1;
          end
        end
        ST_ACTIVE: begin
          cnt_dec = 1'b1;
          // A zero count in ACTIVE means the window was opened unbounded.
          if (disarm || (!cnt_zero && (cnt == CNT_W'(1)))) begin
            state_d = ST_LOADED;
          end
        end
        default: ;
      endcase
    end

    bypass_d   = (state_d == ST_ACTIVE) ? shadow_q[FILTER_SIZE-1:0]     : '0;
    regconst_d = (state_d == ST_ACTIVE) ? shadow_q[IMG_W-1:FILTER_SIZE] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      staging_q  <= '0;
      shadow_q   <= '0;
      cfg_err_q  <= 1'b0;
      bypass_q   <= '0;
      regconst_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      staging_q  <= staging_d;
      shadow_q   <= shadow_d;
      cfg_err_q  <= cfg_err_d;
      bypass_q   <= bypass_d;
      regconst_q <= regconst_d;
    end
  end

  assign BypassEn = bypass_q;
  assign RegConst = regconst_q;
  assign state_o  = state_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_fru_filter_ctrl.sv
// Vector-table and scoreboard bench for fru_filter_ctrl (FILTER_SIZE=10, WORD_W=8).
module tb_fru_filter_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LOADED = 3'd2;
  localparam logic [2:0] S_ARMED  = 3'd3;
  localparam logic [2:0] S_ACTIVE = 3'd4;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        arm;
    logic        dis;
    logic        trg;
    logic [15:0] hold;
    logic [2:0]  st;
    logic [9:0]  byp;
    logic [9:0]  rc;
    logic        err;
    logic        rdy;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic [9:0] byp;
    logic [9:0] rc;
    logic       err;
    logic       rdy;
    string      nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready, cfg_last;
  logic [7:0]  cfg_data;
  logic        arm, disarm, trigger;
  logic [15:0] hold_cycles;
  logic [9:0]  BypassEn, RegConst;
  logic [2:0]  state_o;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  fru_filter_ctrl #(.FILTER_SIZE(10), .WORD_W(8), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .cfg_last    (cfg_last),
    .arm         (arm),
    .disarm      (disarm),
    .trigger     (trigger),
    .hold_cycles (hold_cycles),
    .BypassEn    (BypassEn),
    .RegConst    (RegConst),
    .state_o     (state_o),
    .cfg_err     (cfg_err)
  );

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic a, logic dis, logic t,
                              logic [15:0] h, logic [2:0] st, logic [9:0] b, logic [9:0] r,
                              logic e, logic rdy);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.arm = a; x.dis = dis; x.trg = t; x.hold = h;
    x.st = st; x.byp = b; x.rc = r; x.err = e; x.rdy = rdy;
    return x;
  endfunction

  task automatic push_exp(input logic [2:0] st, input logic [9:0] b, input logic [9:0] r,
                          input logic e, input logic rdy, input string nm);
    exp_t x;
    x.st = st; x.byp = b; x.rc = r; x.err = e; x.rdy = rdy; x.nm = nm;
    exp_q.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    x = exp_q.pop_front();
    checks++;
    if (state_o !== x.st || BypassEn !== x.byp || RegConst !== x.rc ||
        cfg_err !== x.err || cfg_ready !== x.rdy) begin
      errors++;
      $display("FAIL %s: got st=%0d byp=%h rc=%h err=%b rdy=%b, required st=%0d byp=%h rc=%h err=%b rdy=%b",
               x.nm, state_o, BypassEn, RegConst, cfg_err, cfg_ready,
               x.st, x.byp, x.rc, x.err, x.rdy);
    end
  endtask

  task automatic cyc(input vec_t s, input string nm);
    cfg_valid = s.v; cfg_data = s.d; cfg_last = s.l;
    arm = s.arm; disarm = s.dis; trigger = s.trg; hold_cycles = s.hold;
    push_exp(s.st, s.byp, s.rc, s.err, s.rdy, nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_valid = 0; cfg_data = '0; cfg_last = 0;
    arm = 0; disarm = 0; trigger = 0; hold_cycles = '0;

    // Image F3CA5: BypassEn=0A5, RegConst=3CF, 4-cycle window.
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 0, S_LOAD,   10'h000, 10'h000, 0, 1));
    tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 0, 0, S_LOAD,   10'h000, 10'h000, 0, 1));
    tbl.push_back(mk(1, 8'h0F, 1, 0, 0, 0, 0, S_LOADED, 10'h000, 10'h000, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, S_ARMED,  10'h000, 10'h000, 0, 0));
    tbl.push_back(mk(1, 8'h55, 1, 0, 0, 0, 0, S_ARMED,  10'h000, 10'h000, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 4, S_ACTIVE, 10'h0A5, 10'h3CF, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, S_ACTIVE, 10'h0A5, 10'h3CF, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, S_ACTIVE, 10'h0A5, 10'h3CF, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, S_ACTIVE, 10'h0A5, 10'h3CF, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, S_LOADED, 10'h000, 10'h000, 0, 1));
    // Retrigger ignored: window stays 3 cycles from first trigger.
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, S_ARMED,  10'h000, 10'h000, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 3, S_ACTIVE, 10'h0A5, 10'h3CF, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 9, S_ACTIVE, 10'h0A5, 10'h3CF, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, S_ACTIVE, 10'h0A5, 10'h3CF, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, S_LOADED, 10'h000, 10'h000, 0, 1));
    // Disarm beats simultaneous trigger; trigger while LOADED does nothing.
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, S_ARMED,  10'h000, 10'h000, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 5, S_LOADED, 10'h000, 10'h000, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 5, S_LOADED, 10'h000, 10'h000, 0, 1));
    // Early cfg_last -> error, IDLE; arm then ignored.
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0, S_LOAD,   10'h000, 10'h000, 0, 1));
    tbl.push_back(mk(1, 8'h22, 1, 0, 0, 0, 0, S_IDLE,   10'h000, 10'h000, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, S_IDLE,   10'h000, 10'h000, 1, 1));
    // Missing cfg_last on final beat -> error.
    tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0, 0, S_LOAD,   10'h000, 10'h000, 1, 1));
    tbl.push_back(mk(1, 8'h02, 0, 0, 0, 0, 0, S_LOAD,   10'h000, 10'h000, 1, 1));
    tbl.push_back(mk(1, 8'h03, 0, 0, 0, 0, 0, S_IDLE,   10'h000, 10'h000, 1, 1));
    // Good load clears error; upper nibble of last beat ignored: image 0C35A.
    tbl.push_back(mk(1, 8'h5A, 0, 0, 0, 0, 0, S_LOAD,   10'h000, 10'h000, 1, 1));
    tbl.push_back(mk(1, 8'hC3, 0, 0, 0, 0, 0, S_LOAD,   10'h000, 10'h000, 1, 1));
    tbl.push_back(mk(1, 8'hF0, 1, 0, 0, 0, 0, S_LOADED, 10'h000, 10'h000, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, S_ARMED,  10'h000, 10'h000, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, S_ACTIVE, 10'h35A, 10'h030, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, S_LOADED, 10'h000, 10'h000, 0, 1));

    #12;
    push_exp(S_IDLE, 10'h000, 10'h000, 0, 1, "reset_state");
    check_out();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i], $sformatf("vec%0d", i));
    end

    // Unbounded window held until disarm.
    cyc(mk(0, 0, 0, 1, 0, 0, 0, S_ARMED,  10'h000, 10'h000, 0, 0), "unb_arm");
    cyc(mk(0, 0, 0, 0, 0, 1, 0, S_ACTIVE, 10'h35A, 10'h030, 0, 0), "unb_trig");
    for (int i = 0; i < 100; i++) begin
      cyc(mk(0, 0, 0, 0, 0, 0, 0, S_ACTIVE, 10'h35A, 10'h030, 0, 0), $sformatf("unb_hold%0d", i));
    end
    cyc(mk(0, 0, 0, 0, 1, 0, 0, S_LOADED, 10'h000, 10'h000, 0, 1), "unb_disarm");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, S_LOADED, 10'h000, 10'h000, 0, 1), "unb_after");

    // Reset mid-window discards everything immediately.
    cyc(mk(0, 0, 0, 1, 0, 0, 0,  S_ARMED,  10'h000, 10'h000, 0, 0), "rst_arm");
    cyc(mk(0, 0, 0, 0, 0, 1, 50, S_ACTIVE, 10'h35A, 10'h030, 0, 0), "rst_trig");
    for (int i = 0; i < 3; i++) begin
      cyc(mk(0, 0, 0, 0, 0, 0, 0, S_ACTIVE, 10'h35A, 10'h030, 0, 0), $sformatf("rst_hold%0d", i));
    end
    rst_n = 1'b0;
    #1;
    push_exp(S_IDLE, 10'h000, 10'h000, 0, 1, "rst_async");
    check_out();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(mk(0, 0, 0, 1, 0, 0, 0, S_IDLE, 10'h000, 10'h000, 0, 1), "rst_arm_ignored");
    cyc(mk(0, 0, 0, 0, 0, 1, 7, S_IDLE, 10'h000, 10'h000, 0, 1), "rst_trig_ignored");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
